// File: rtl/parking_time_recorder.sv
`default_nettype none
// ============================================================================
// Module      : parking_time_recorder
// Description : Free-running time base plus per-slot entry stamps. On exit,
//               presents the (time_in, time_out) pair with a valid/ready hold.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_time_recorder #(
    parameter int SLOTS    = 4,
    parameter int SLOT_W   = 2,
    parameter int TIME_W   = 8,
    parameter int TICK_DIV = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              car_enter,
    input  logic [SLOT_W-1:0] enter_slot,
    input  logic              car_exit,
    input  logic [SLOT_W-1:0] exit_slot,
    input  logic              stamp_ready,
    output logic [TIME_W-1:0] time_now,
    output logic [TIME_W-1:0] time_in,
    output logic [TIME_W-1:0] time_out,
    output logic              stamp_valid,
    output logic              exit_ready,
    output logic [SLOTS-1:0]  occupied,
    output logic              err
);

    localparam int                    c_presc_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_presc_w-1:0]  c_presc_max = c_presc_w'(TICK_DIV - 1);
    localparam logic [SLOT_W:0]       c_slots     = (SLOT_W + 1)'(SLOTS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_presc_w-1:0] r_presc;
    logic [TIME_W-1:0]   r_time_now;
    logic [TIME_W-1:0]   r_table [SLOTS];
    logic [SLOTS-1:0]    r_occupied;
    logic [SLOTS-1:0]    w_occ_next;
    logic [TIME_W-1:0]   r_time_in;
    logic [TIME_W-1:0]   r_time_out;
    logic                r_err;

    logic                w_tick;
    logic                w_enter_in_range;
    logic                w_exit_in_range;
    logic                w_exit_hit;
    logic                w_exit_ok;
    logic                w_enter_ok;
    logic                w_same_slot;
    logic                w_err_next;
    logic                w_exit_ready;

    // ------------------------------------------------------------------
    // Time base
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == c_presc_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_time_now <= '0;
        end else if (w_tick) begin
            r_presc    <= '0;
            r_time_now <= r_time_now + TIME_W'(1);
        end else begin
            r_presc    <= r_presc + c_presc_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign w_enter_in_range = ({1'b0, enter_slot} < c_slots);
    assign w_exit_in_range  = ({1'b0, exit_slot} < c_slots);
    assign w_exit_hit       = w_exit_in_range && r_occupied[exit_slot];
    assign w_same_slot      = (enter_slot == exit_slot);

    // An occupied slot may be re-entered only in the cycle it is being vacated.
    assign w_enter_ok = car_enter && w_enter_in_range &&
                        (!r_occupied[enter_slot] || (w_exit_ok && w_same_slot));

    assign w_err_next = (car_enter && !w_enter_ok) || (car_exit && !w_exit_ok);

    // ------------------------------------------------------------------
    // Exit handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_exit_ready = 1'b0;
        w_exit_ok    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_exit_ready = 1'b1;
                w_exit_ok    = car_exit && w_exit_hit;
                if (w_exit_ok) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (stamp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Occupancy, entry table and stamp registers
    // ------------------------------------------------------------------
    always_comb begin
        w_occ_next = r_occupied;
        for (int i = 0; i < SLOTS; i++) begin
            if (w_exit_ok && (exit_slot == SLOT_W'(i))) begin
                w_occ_next[i] = 1'b0;
            end
            // Set wins so a same-slot exit+entry leaves the slot occupied.
            if (w_enter_ok && (enter_slot == SLOT_W'(i))) begin
                w_occ_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occupied <= '0;
            r_err      <= 1'b0;
            r_time_in  <= '0;
            r_time_out <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_occupied <= w_occ_next;
            r_err      <= w_err_next;
            if (w_enter_ok) begin
                r_table[enter_slot] <= r_time_now;
            end
            if (w_exit_ok) begin
                r_time_in  <= r_table[exit_slot];
                r_time_out <= r_time_now;
            end
        end
    end

    assign time_now    = r_time_now;
    assign time_in     = r_time_in;
    assign time_out    = r_time_out;
    assign stamp_valid = (r_state == ST_HOLD);
    assign exit_ready  = w_exit_ready;
    assign occupied    = r_occupied;
    assign err         = r_err;

endmodule
`default_nettype wire
